// File: rtl/tart_acquire_stream.sv
// tart_acquire_stream: strobe-driven antenna sample capture with decimation,
// an 8-entry FIFO and sequential single-word writes to the memory controller.
//
// Ports:
//   clock_i, reset_i            bus clock, async active-high reset
//   start_i, abort_i            capture control (start only honoured in IDLE)
//   length_i, decim_i           capture length (0 = 2^CBITS) and keep-1-in-N
//   locked_i, strobe_i, signal_i  sample source
//   mcb_ce_o, mcb_wr_o, mcb_adr_o, mcb_dat_o, mcb_rdy_i  memory write port
//   busy_o, done_o, oflow_o, unlock_o, count_o, state_o  status
`timescale 1ns/1ps
module tart_acquire_stream #(
    parameter int AXNUM = 24,
    parameter int WIDTH = 32,
    parameter int ABITS = 21,
    parameter int CBITS = 10,
    parameter int FBITS = 3,
    parameter int DBITS = 4,
    parameter int BASE  = 0,
    parameter int DELAY = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CBITS-1:0] length_i,
    input  logic [DBITS-1:0] decim_i,
    input  logic             locked_i,
    input  logic             strobe_i,
    input  logic [AXNUM-1:0] signal_i,
    output logic             mcb_ce_o,
    input  logic             mcb_rdy_i,
    output logic             mcb_wr_o,
    output logic [ABITS-1:0] mcb_adr_o,
    output logic [WIDTH-1:0] mcb_dat_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             oflow_o,
    output logic             unlock_o,
    output logic [CBITS:0]   count_o,
    output logic [2:0]       state_o
);

    if (AXNUM > WIDTH || DELAY < 0) begin : g_bad_params
        $error("tart_acquire_stream: AXNUM must not exceed WIDTH");
    end

    localparam int DEPTH = 1 << FBITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [AXNUM-1:0] mem [DEPTH];
    logic [FBITS-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [FBITS:0]   fcnt, occ;
    logic [CBITS:0]   len_q, tally_q, tally_n, count_q;
    logic [DBITS-1:0] decim_q, dcnt_q;
    logic [ABITS-1:0] adr_q;
    logic [AXNUM-1:0] head_q;
    logic             ce_q, oflow_q, unlock_q;
    logic             full, cap, keep, push, pop, last;

    always_comb begin
        full     = (fcnt == (FBITS+1)'(DEPTH));
        cap      = strobe_i && locked_i && !abort_i &&
                   (state_q == S_ARMED || state_q == S_CAPTURE);
        keep     = cap && (dcnt_q == '0);
        // a full FIFO drops the sample even if a pop happens this cycle
        push     = keep && !full;
        pop      = ce_q && mcb_rdy_i;
        tally_n  = tally_q + (CBITS+1)'(keep);
        last     = keep && (tally_n == len_q);
        rd_ptr_n = rd_ptr + FBITS'(pop);
        occ      = fcnt - (FBITS+1)'(pop);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start_i) state_d = S_ARMED;
            S_ARMED:   if (abort_i) state_d = S_DRAIN;
                       else if (keep) state_d = last ? S_DRAIN : S_CAPTURE;
            S_CAPTURE: if (abort_i || last) state_d = S_DRAIN;
            S_DRAIN:   if (fcnt == '0 && !ce_q) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            len_q    <= '0;
            decim_q  <= '0;
            dcnt_q   <= '0;
            tally_q  <= '0;
            count_q  <= '0;
            oflow_q  <= 1'b0;
            unlock_q <= 1'b0;
            adr_q    <= ABITS'(BASE);
        end else if (state_q == S_IDLE && start_i) begin
            len_q    <= {length_i == '0, length_i};
            decim_q  <= decim_i;
            dcnt_q   <= '0;
            tally_q  <= '0;
            count_q  <= '0;
            oflow_q  <= 1'b0;
            unlock_q <= 1'b0;
            adr_q    <= ABITS'(BASE);
        end else begin
            if (cap)
                dcnt_q <= (dcnt_q == '0) ? decim_q : dcnt_q - DBITS'(1);
            tally_q <= tally_n;
            if (keep && full)
                oflow_q <= 1'b1;
            if (state_q == S_CAPTURE && strobe_i && !locked_i && !abort_i)
                unlock_q <= 1'b1;
            if (pop) begin
                adr_q   <= adr_q + ABITS'(1);
                count_q <= count_q + (CBITS+1)'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= signal_i;
    end

    // The head register shows the oldest entry still in the FIFO; the entry
    // is only released on acceptance, so total storage stays at DEPTH words.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            ce_q   <= 1'b0;
            head_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FBITS'(1);
            rd_ptr <= rd_ptr_n;
            fcnt   <= occ + (FBITS+1)'(push);
            ce_q   <= (occ != '0);
            if (occ != '0) head_q <= mem[rd_ptr_n];
        end
    end

    assign mcb_ce_o  = ce_q;
    assign mcb_wr_o  = ce_q;
    assign mcb_adr_o = adr_q;
    assign mcb_dat_o = WIDTH'(head_q);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign oflow_o   = oflow_q;
    assign unlock_o  = unlock_q;
    assign count_o   = count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_tart_acquire_stream.sv
// tb_tart_acquire_stream: directed stimulus with a write scoreboard for
// tart_acquire_stream.
`timescale 1ns/1ps
module tb_tart_acquire_stream;

    localparam int AXNUM = 24;
    localparam int WIDTH = 32;
    localparam int ABITS = 21;
    localparam int CBITS = 10;
    localparam int DBITS = 4;

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [CBITS-1:0] length_i = '0;
    logic [DBITS-1:0] decim_i = '0;
    logic             locked_i = 1'b1;
    logic             strobe_i = 1'b0;
    logic [AXNUM-1:0] signal_i = '0;
    logic             mcb_rdy_i = 1'b0;
    logic             mcb_ce_o, mcb_wr_o, busy_o, done_o, oflow_o, unlock_o;
    logic [ABITS-1:0] mcb_adr_o;
    logic [WIDTH-1:0] mcb_dat_o;
    logic [CBITS:0]   count_o;
    logic [2:0]       state_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit saw_drain = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_v;
    logic [ABITS-1:0] exp_adr = '0;

    always #5 clock_i = ~clock_i;

    tart_acquire_stream dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .start_i(start_i), .abort_i(abort_i),
        .length_i(length_i), .decim_i(decim_i),
        .locked_i(locked_i), .strobe_i(strobe_i),
        .signal_i(signal_i),
        .mcb_ce_o(mcb_ce_o), .mcb_rdy_i(mcb_rdy_i),
        .mcb_wr_o(mcb_wr_o), .mcb_adr_o(mcb_adr_o),
        .mcb_dat_o(mcb_dat_o),
        .busy_o(busy_o), .done_o(done_o),
        .oflow_o(oflow_o), .unlock_o(unlock_o),
        .count_o(count_o), .state_o(state_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes are checked half a cycle before the accepting edge.
    always @(negedge clock_i) begin
        if (done_o) done_cnt++;
        if (state_o == 3'd3) saw_drain = 1'b1;
        if (!reset_i && mcb_ce_o && mcb_rdy_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none",
                       mcb_dat_o);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                chk("wr_data", mcb_dat_o, exp_v);
                chk("wr_addr", mcb_adr_o, exp_adr);
                chk("wr_flag", mcb_wr_o, 1);
                exp_adr = exp_adr + 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_cap(input int len, input int dec);
        exp_adr  = '0;
        length_i = CBITS'(len);
        decim_i  = DBITS'(dec);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic strobe(input int sig, input bit lk, input int gap);
        signal_i = AXNUM'(sig);
        locked_i = lk;
        strobe_i = 1'b1;
        tick();
        strobe_i = 1'b0;
        locked_i = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input int base, input int budget,
                             input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk(tag, done_cnt, base + 1);
    endtask

    initial begin
        int b, m, k, n;
        bit lk;

        repeat (3) tick();
        chk("rst_ce", mcb_ce_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_adr", mcb_adr_o, 0);
        reset_i = 1'b0;
        tick();

        // plain capture, no decimation
        mcb_rdy_i = 1'b1;
        b = done_cnt;
        start_cap(16, 0);
        chk("t1_armed", state_o, 1);
        chk("t1_busy", busy_o, 1);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(WIDTH'(i));
            strobe(i, 1'b1, 5);
        end
        wait_done(b, 100, "t1_done");
        chk("t1_count", count_o, 16);
        chk("t1_oflow", oflow_o, 0);
        chk("t1_unlock", unlock_o, 0);
        chk("t1_idle", state_o, 0);
        chk("t1_sb", exp_q.size(), 0);

        // decimation by 3
        b = done_cnt;
        start_cap(4, 2);
        m = 0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (k < 4) begin
                if (m == 0) begin
                    exp_q.push_back(WIDTH'(i));
                    k++;
                    m = 2;
                end else begin
                    m--;
                end
            end
            strobe(i, 1'b1, 5);
        end
        wait_done(b, 100, "t2_done");
        chk("t2_count", count_o, 4);
        chk("t2_sb", exp_q.size(), 0);

        // stalled memory: FIFO fills, rest dropped
        mcb_rdy_i = 1'b0;
        b = done_cnt;
        start_cap(20, 0);
        locked_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) exp_q.push_back(WIDTH'(i));
            signal_i = AXNUM'(i);
            strobe_i = 1'b1;
            tick();
        end
        strobe_i = 1'b0;
        chk("t3_drain", state_o, 3);
        chk("t3_oflow", oflow_o, 1);
        chk("t3_ce", mcb_ce_o, 1);
        chk("t3_count0", count_o, 0);
        repeat (78) tick();
        chk("t3_hold_dat", mcb_dat_o, 0);
        chk("t3_hold_ce", mcb_ce_o, 1);
        chk("t3_nodone", done_cnt, b);
        mcb_rdy_i = 1'b1;
        wait_done(b, 100, "t3_done");
        chk("t3_count", count_o, 8);
        chk("t3_oflow_held", oflow_o, 1);
        chk("t3_sb", exp_q.size(), 0);

        // loss of lock for three strobes
        b = done_cnt;
        start_cap(10, 0);
        for (int i = 0; i < 13; i++) begin
            lk = !(i >= 4 && i <= 6);
            if (lk) exp_q.push_back(WIDTH'(i));
            strobe(i, lk, 5);
        end
        wait_done(b, 100, "t4_done");
        chk("t4_unlock", unlock_o, 1);
        chk("t4_count", count_o, 10);
        chk("t4_oflow", oflow_o, 0);
        chk("t4_sb", exp_q.size(), 0);

        // abort after five samples
        b = done_cnt;
        saw_drain = 1'b0;
        start_cap(64, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(WIDTH'(i));
            strobe(i, 1'b1, 5);
        end
        chk("t5_capture", state_o, 2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5_drain_state", state_o, 3);
        wait_done(b, 50, "t5_done");
        repeat (10) tick();
        chk("t5_once", done_cnt, b + 1);
        chk("t5_saw_drain", saw_drain, 1);
        chk("t5_count", count_o, 5);
        chk("t5_sb", exp_q.size(), 0);

        // reset while a write is pending
        b = done_cnt;
        mcb_rdy_i = 1'b1;
        start_cap(16, 0);
        exp_q.push_back(WIDTH'(32'h11));
        strobe(32'h11, 1'b1, 5);
        mcb_rdy_i = 1'b0;
        exp_q.push_back(WIDTH'(32'h22));
        strobe(32'h22, 1'b1, 0);
        n = 0;
        while (!mcb_ce_o && n < 20) begin
            tick();
            n++;
        end
        chk("t6_pending", mcb_ce_o, 1);
        chk("t6_count1", count_o, 1);
        reset_i = 1'b1;
        #1;
        chk("t6_rst_ce", mcb_ce_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_state", state_o, 0);
        chk("t6_rst_adr", mcb_adr_o, 0);
        exp_q.delete();
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("t6_nodone", done_cnt, b);
        mcb_rdy_i = 1'b1;
        b = done_cnt;
        start_cap(1, 0);
        exp_q.push_back(WIDTH'(32'h55));
        strobe(32'h55, 1'b1, 5);
        wait_done(b, 50, "t6_done");
        chk("t6_count", count_o, 1);
        chk("t6_sb", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tart_acquire_stream.md
Name: tart_acquire_stream

Overview:
Parametrised successor to the raw-data acquisition datapath. It captures AXNUM-bit antenna samples on each strobe while the receiver is locked, with programmable decimation and capture length. Samples are buffered in a small FIFO and streamed as sequential single-word writes to the memory controller (Hamster SDRAM or the dummy MCB). It sits between the signal-capture/strobe logic and the MCB in the bus clock domain; a higher-level Wishbone front-end drives its start/abort controls.

Parameters:
AXNUM, 24, antenna sample width; must be ≤ WIDTH
WIDTH, 32, MCB data width; samples are zero-extended to WIDTH
ABITS, 21, MCB word-address width
CBITS, 10, capture-length counter width; maximum 2^CBITS samples
FBITS, 3, log2 of FIFO depth (8 entries)
DBITS, 4, decimation-field width
BASE, 0, first MCB word address of each capture
DELAY, 3, simulation register delay (ns)

Ports:
clock_i  in  1  bus clock
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse; arms a capture (ignored unless IDLE)
abort_i  in  1  ends capture early, then drains the FIFO
length_i  in  CBITS  sample count; 0 means 2^CBITS; latched on start
decim_i  in  DBITS  keep 1 strobe in (decim_i+1); latched on start
locked_i  in  1  receiver locked / signal valid
strobe_i  in  1  one-cycle new-sample strobe
signal_i  in  AXNUM  antenna sample, valid with strobe_i
mcb_ce_o  out  1  write-request, held until accepted
mcb_rdy_i  in  1  MCB can accept a command
mcb_wr_o  out  1  write flag; equals mcb_ce_o
mcb_adr_o  out  ABITS  word address
mcb_dat_o  out  WIDTH  write data
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse when a capture completes
oflow_o  out  1  sticky: a sample was dropped because the FIFO was full
unlock_o  out  1  sticky: a strobe arrived with locked_i low during CAPTURE
count_o  out  CBITS+1  words written to memory in the current capture
state_o  out  3  IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, DONE=4

Behaviour:
- Reset (async) clears all outputs, the FIFO, and all counters. Address returns to BASE. State goes to IDLE.
- IDLE: start_i pulse latches length_i and decim_i; clears oflow_o, unlock_o, count_o; sets address=BASE and decimation counter=0; moves to ARMED.
- ARMED: the first strobe_i with locked_i=1 is treated as a CAPTURE strobe in that same cycle, so it is the first sample kept. Strobes with locked_i=0 are ignored here and do not set unlock_o.
- CAPTURE, on each strobe_i with locked_i=1:
  - If the decimation counter is 0, push {zero pad, signal_i} and reload the counter with the latched decim; otherwise decrement the counter.
  - A push attempted when the registered full flag is set is dropped, and oflow_o is set. Full is evaluated before any same-cycle pop.
  - Dropped samples still count toward length, so the capture time stays deterministic.
  - When the kept-sample tally reaches length, move to DRAIN on the next cycle.
- CAPTURE, strobe_i with locked_i=0: no push, decimation counter unchanged, unlock_o set.
- abort_i in ARMED or CAPTURE moves to DRAIN; a strobe in the same cycle is discarded. abort_i in other states is ignored.
- Write side (active in CAPTURE and DRAIN):
  - When the FIFO is non-empty, assert mcb_ce_o=mcb_wr_o=1 with mcb_dat_o = FIFO head and mcb_adr_o = current address.
  - A write is accepted on a rising edge where mcb_ce_o and mcb_rdy_i are both high. On acceptance: pop the FIFO, address+1 (wraps modulo 2^ABITS), count_o+1.
  - Outputs hold stable while mcb_rdy_i is low.
  - First write request appears 2 cycles after the accepted strobe: FIFO write, then registered head.
- DRAIN: when the FIFO is empty and no request is pending, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. Sticky flags and count_o hold until the next start.
- A simultaneous FIFO push and pop while not full are both performed, and occupancy is unchanged.
- start_i outside IDLE is ignored.
- reset_i mid-capture aborts immediately. No done_o is issued and the request drops asynchronously.

Test Plan:
- length=16, decim=0, locked high, mcb_rdy_i always 1, strobes every 6 cycles, signal=index → 16 writes at addresses 0..15 with data 0..15, count_o=16, one done_o pulse, oflow_o=0.
- decim=2, length=4, 12 strobes with signal=index → data written is 0,3,6,9.
- mcb_rdy_i held low for 100 cycles, strobe every cycle, length=20 → exactly 8 words written (0..7), oflow_o=1, done_o after rdy returns, count_o=8.
- locked_i low for 3 strobes mid-capture, length=10 → unlock_o=1, 10 words written, the unlocked-strobe samples are absent.
- abort_i after 5 kept samples, length=64 → 5 words written, state passes DRAIN then DONE, done_o pulses once.
- reset_i asserted while mcb_ce_o=1 → mcb_ce_o, busy_o, and count_o all go to 0 immediately, state=IDLE; a subsequent start writes again from address BASE.
